// File: rtl/alu_lane_issuer.sv
// Issues a packed multi-lane operation one byte lane per cycle to a shared
// 8-bit ALU and reassembles the per-lane results into a packed response.
module alu_lane_issuer #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LANES*8-1:0] req_a,
    input  logic [LANES*8-1:0] req_b,
    input  logic [3:0]         req_func,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [LANES*8-1:0] resp_data,
    output logic               resp_zero,
    output logic               resp_err,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [3:0]         alu_func,
    input  logic [7:0]         alu_result
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state_q, state_d;
    logic [LANES*8-1:0] a_q, a_d, b_q, b_d;
    logic [LANES*8-1:0] res_q, res_d, res_next;
    logic [3:0]         func_q, func_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LANES*8-1:0] resp_data_q, resp_data_d;
    logic               resp_zero_q, resp_zero_d;
    logic               resp_err_q, resp_err_d;
    logic               func_ok;
    logic [7:0]         a_lane [LANES];
    logic [7:0]         b_lane [LANES];

    // Per-lane operand views and the result vector with the current lane replaced.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign a_lane[gi] = a_q[gi*8 +: 8];
            assign b_lane[gi] = b_q[gi*8 +: 8];
            assign res_next[gi*8 +: 8] =
                ((state_q == ISSUE) && (idx_q == IDX_W'(gi))) ? alu_result : res_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        case (req_func)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110,
            4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: func_ok = 1'b1;
            default:                                     func_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        func_d      = func_q;
        idx_d       = idx_q;
        res_d       = res_q;
        resp_data_d = resp_data_q;
        resp_zero_d = resp_zero_q;
        resp_err_d  = resp_err_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        alu_a       = 8'd0;
        alu_b       = 8'd0;
        alu_func    = 4'd0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d    = req_a;
                    b_d    = req_b;
                    func_d = req_func;
                    idx_d  = '0;
                    if (func_ok) begin
                        state_d = ISSUE;
                    end else begin
                        // Unsupported code: answer immediately without touching the ALU.
                        state_d     = RESP;
                        resp_data_d = '0;
                        resp_zero_d = 1'b0;
                        resp_err_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                alu_a    = a_lane[idx_q];
                alu_b    = b_lane[idx_q];
                alu_func = func_q;
                res_d    = res_next;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d     = RESP;
                    idx_d       = '0;
                    resp_data_d = res_next;
                    resp_zero_d = (res_next == '0);
                    resp_err_d  = 1'b0;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            func_q      <= '0;
            idx_q       <= '0;
            res_q       <= '0;
            resp_data_q <= '0;
            resp_zero_q <= 1'b0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            func_q      <= func_d;
            idx_q       <= idx_d;
            res_q       <= res_d;
            resp_data_q <= resp_data_d;
            resp_zero_q <= resp_zero_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign resp_data = resp_data_q;
    assign resp_zero = resp_zero_q;
    assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_alu_lane_issuer.sv
// Self-checking bench for alu_lane_issuer: directed scenarios plus randomized
// transactions compared against a lane-by-lane reference model.
module tb_alu_lane_issuer;

    localparam int LANES = 4;
    localparam int W     = LANES * 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [3:0]   req_func = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] resp_data;
    logic         resp_zero;
    logic         resp_err;
    logic [7:0]   alu_a, alu_b, alu_result;
    logic [3:0]   alu_func;

    int vectors = 0;
    int miscompares = 0;

    // Observations gathered by do_txn
    logic         obs_ready;
    int           obs_lat;
    logic [W-1:0] obs_data;
    logic         obs_zero, obs_err, obs_stable, obs_idle;
    logic [3:0]   obs_f_or;
    logic [7:0]   tr_a [LANES];
    logic [7:0]   tr_b [LANES];
    logic [3:0]   tr_f [LANES];

    alu_lane_issuer #(.LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_func   (req_func),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic supported(input logic [3:0] f);
        return f inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    endfunction

    // Behaviour of the external 8-bit ALU
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        logic [15:0] p;
        logic [7:0]  r;
        p = 16'(a) * 16'(b);
        case (f)
            4'h0:    r = a & b;
            4'h1:    r = a | b;
            4'h2:    r = a ^ b;
            4'h3:    r = a + b;
            4'h4:    r = a - b;
            4'h6:    r = ~a;
            4'h8:    r = p[7:0];
            4'h9:    r = a << b[2:0];
            4'hA:    r = a >> b[2:0];
            4'hB:    r = 8'($signed(a) >>> b[2:0]);
            4'hC:    r = {a[6:0], a[7]};
            default: r = 8'hEE;
        endcase
        return r;
    endfunction

    always_comb alu_result = alu_model(alu_a, alu_b, alu_func);

    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f,
                             output logic [W-1:0] d, output logic z, output logic e);
        d = '0;
        e = !supported(f);
        if (!e)
            for (int i = 0; i < LANES; i++) d[8*i +: 8] = alu_model(a[8*i +: 8], b[8*i +: 8], f);
        z = !e && (d == '0);
    endtask

    // Enters and exits just after a falling edge. hold = cycles of resp backpressure.
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f, input int hold);
        obs_ready  = req_ready;
        obs_f_or   = alu_func;
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_func   = f;
        obs_lat    = -1;
        obs_stable = 1'b1;
        obs_idle   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            tr_a[i] = 8'hxx; tr_b[i] = 8'hxx; tr_f[i] = 4'hx;
        end
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_a     = W'($urandom);
            req_b     = W'($urandom);
            req_func  = 4'($urandom);
            obs_f_or  = obs_f_or | alu_func;
            if (resp_valid === 1'b1) begin
                obs_lat  = c;
                obs_data = resp_data;
                obs_zero = resp_zero;
                obs_err  = resp_err;
                break;
            end
            if (c <= LANES) begin
                tr_a[c-1] = alu_a; tr_b[c-1] = alu_b; tr_f[c-1] = alu_func;
            end
        end
        $display("txn func=%h a=%h b=%h -> data=%h zero=%b err=%b lat=%0d hold=%0d",
                 f, a, b, obs_data, obs_zero, obs_err, obs_lat, hold);
        if (obs_lat < 0) return;
        if ({alu_a, alu_b, alu_func} !== 20'd0) obs_stable = 1'b0;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_a     = W'($urandom);
            req_b     = W'($urandom);
            req_func  = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
            obs_f_or = obs_f_or | alu_func;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== obs_data ||
                resp_zero !== obs_zero || resp_err !== obs_err) obs_stable = 1'b0;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        obs_idle = (resp_valid === 1'b0) && (req_ready === 1'b1) && (resp_data === obs_data) &&
                   ({alu_a, alu_b, alu_func} === 20'd0);
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_a     = 32'h12345678;
        req_func  = 4'h3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        vectors++;
        if ({req_ready, resp_valid, resp_zero, resp_err} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got ready/valid/zero/err=%b expected 1000",
                     {req_ready, resp_valid, resp_zero, resp_err});
        end
        vectors++;
        if (resp_data !== 32'd0 || {alu_a, alu_b, alu_func} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_data: got data=%h alu=%h expected 0/0", resp_data, {alu_a, alu_b, alu_func});
        end
    endtask

    task automatic test_add;
        do_txn(32'h01FF7F10, 32'h01010110, 4'h3, 0);
        vectors++;
        if (obs_ready !== 1'b1 || obs_lat != LANES + 1) begin
            miscompares++;
            $display("FAIL add_latency: got ready=%b lat=%0d expected 1/%0d", obs_ready, obs_lat, LANES + 1);
        end
        vectors++;
        if ({obs_data, obs_zero, obs_err} !== {32'h02008020, 2'b00}) begin
            miscompares++;
            $display("FAIL add_data: got %h z=%b e=%b expected 02008020 z=0 e=0", obs_data, obs_zero, obs_err);
        end
        vectors++;
        if ({tr_a[3], tr_a[2], tr_a[1], tr_a[0]} !== 32'h01FF7F10 ||
            {tr_b[3], tr_b[2], tr_b[1], tr_b[0]} !== 32'h01010110) begin
            miscompares++;
            $display("FAIL add_lane_order: got a=%h b=%h expected 01ff7f10/01010110",
                     {tr_a[3], tr_a[2], tr_a[1], tr_a[0]}, {tr_b[3], tr_b[2], tr_b[1], tr_b[0]});
        end
        vectors++;
        if ({tr_f[3], tr_f[2], tr_f[1], tr_f[0]} !== 16'h3333 || obs_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL add_func_idle: got funcs=%h idle=%b expected 3333/1",
                     {tr_f[3], tr_f[2], tr_f[1], tr_f[0]}, obs_idle);
        end
    endtask

    task automatic test_mult;
        do_txn(32'h02100F03, 32'h03101105, 4'h8, 0);
        vectors++;
        if (obs_data !== 32'h0600FF0F || obs_lat != LANES + 1) begin
            miscompares++;
            $display("FAIL mult_data: got %h lat=%0d expected 0600ff0f lat=%0d", obs_data, obs_lat, LANES + 1);
        end
    endtask

    task automatic test_unsupported;
        do_txn(W'($urandom), W'($urandom), 4'h5, 1);
        vectors++;
        if (obs_lat != 1) begin
            miscompares++;
            $display("FAIL unsup_latency: got %0d expected 1", obs_lat);
        end
        vectors++;
        if ({obs_data, obs_zero, obs_err} !== {32'd0, 2'b01}) begin
            miscompares++;
            $display("FAIL unsup_resp: got %h z=%b e=%b expected 0 z=0 e=1", obs_data, obs_zero, obs_err);
        end
        vectors++;
        if (obs_f_or !== 4'd0 || obs_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL unsup_alu_func: got func_or=%h idle=%b expected 0/1", obs_f_or, obs_idle);
        end
    endtask

    task automatic test_zero;
        do_txn(32'hA5C33C5A, 32'hA5C33C5A, 4'h2, 0);
        vectors++;
        if ({obs_data, obs_zero, obs_err} !== {32'd0, 2'b10}) begin
            miscompares++;
            $display("FAIL zero_flag: got %h z=%b e=%b expected 0 z=1 e=0", obs_data, obs_zero, obs_err);
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] a, b, ed;
        logic         ez, ee;
        a = W'($urandom); b = W'($urandom);
        ref_model(a, b, 4'h3, ed, ez, ee);
        do_txn(a, b, 4'h3, 3);
        vectors++;
        if (obs_stable !== 1'b1 || obs_idle !== 1'b1 || obs_data !== ed) begin
            miscompares++;
            $display("FAIL bp_hold: got stable=%b idle=%b data=%h expected 1/1/%h", obs_stable, obs_idle, obs_data, ed);
        end
        a = W'($urandom); b = W'($urandom);
        ref_model(a, b, 4'h4, ed, ez, ee);
        do_txn(a, b, 4'h4, 0);
        vectors++;
        if (obs_ready !== 1'b1 || obs_lat != LANES + 1 || obs_data !== ed) begin
            miscompares++;
            $display("FAIL bp_next_accept: got ready=%b lat=%0d data=%h expected 1/%0d/%h",
                     obs_ready, obs_lat, obs_data, LANES + 1, ed);
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] a, b, ed;
        logic         ez, ee;
        req_valid = 1'b1;
        req_a     = 32'h44332211;
        req_b     = 32'h01010101;
        req_func  = 4'h3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (alu_a !== 8'h33) begin
            miscompares++;
            $display("FAIL rstmid_lane2: got alu_a=%h expected 33", alu_a);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({req_ready, resp_valid} !== 2'b10 || resp_data !== 32'd0 || {alu_a, alu_b, alu_func} !== 20'd0) begin
            miscompares++;
            $display("FAIL rstmid_idle: got ready=%b valid=%b data=%h alu=%h expected 1/0/0/0",
                     req_ready, resp_valid, resp_data, {alu_a, alu_b, alu_func});
        end
        a = W'($urandom); b = W'($urandom);
        ref_model(a, b, 4'h3, ed, ez, ee);
        do_txn(a, b, 4'h3, 0);
        vectors++;
        if (obs_data !== ed || obs_lat != LANES + 1 || obs_zero !== ez) begin
            miscompares++;
            $display("FAIL rstmid_after: got %h lat=%0d expected %h lat=%0d", obs_data, obs_lat, ed, LANES + 1);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, ed;
        logic [3:0]   f;
        logic         ez, ee;
        int           elat;
        for (int n = 0; n < 40; n++) begin
            a = W'($urandom);
            b = (n % 5 == 0) ? a : W'($urandom);
            f = 4'($urandom_range(0, 15));
            ref_model(a, b, f, ed, ez, ee);
            elat = ee ? 1 : LANES + 1;
            do_txn(a, b, f, int'($urandom_range(0, 2)));
            vectors++;
            if (obs_data !== ed || obs_zero !== ez || obs_err !== ee || obs_lat != elat ||
                obs_idle !== 1'b1 || obs_stable !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_txn%0d: got data=%h z=%b e=%b lat=%0d idle=%b stable=%b expected %h z=%b e=%b lat=%0d",
                         n, obs_data, obs_zero, obs_err, obs_lat, obs_idle, obs_stable, ed, ez, ee, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mult();
        test_unsupported();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
